// File: rtl/char_printer_if.sv
// Byte stream from the character printer to the UART TX.
// A byte moves on a rising edge where valid and ready are both high.
interface char_printer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/char_printer.sv
// Fetches one packed-ASCII ROM word and streams it MSB byte first,
// stopping at the first NUL, optionally followed by a hex byte.
module char_printer #(
  parameter int WIDTH = 64,
  parameter int DEPL2 = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DEPL2-1:0]   msg_i,
  input  logic               hex_en_i,
  input  logic [7:0]         hex_i,
  output logic [DEPL2-1:0]   rom_addr_o,
  input  logic [WIDTH-1:0]   rom_data_i,
  char_printer_if.master     tx,
  output logic               busy_o,
  output logic               done_o
);
  localparam int NB = WIDTH / 8;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_SEND,
    S_HEXHI,
    S_HEXLO,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             hen_q;
  logic [7:0]       hex_q;
  logic [DEPL2-1:0] addr_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] sh_d;
  logic [7:0]       nxt_d;
  logic             xfer;
  logic             last_d;

  function automatic logic [7:0] hex2asc(input logic [3:0] n);
    hex2asc = (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction

  assign sh_d   = sh_q << 8;
  assign nxt_d  = sh_d[WIDTH-1 -: 8];
  assign xfer   = valid_q & tx.ready;
  // String ends on the word's last byte or just before a NUL.
  assign last_d = (cnt_q == CW'(NB - 1)) || (nxt_d == 8'h00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      hen_q   <= 1'b0;
      hex_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q  <= msg_i;
            hen_q   <= hex_en_i;
            hex_q   <= hex_i;
            busy_q  <= 1'b1;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: state_q <= S_LOAD;
        S_LOAD: begin
          sh_q  <= rom_data_i;
          cnt_q <= '0;
          if (rom_data_i[WIDTH-1 -: 8] != 8'h00) begin
            data_q  <= rom_data_i[WIDTH-1 -: 8];
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end else if (hen_q) begin
            data_q  <= hex2asc(hex_q[7:4]);
            valid_q <= 1'b1;
            state_q <= S_HEXHI;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_SEND: begin
          if (xfer) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 1'b1;
            if (!last_d) begin
              data_q <= nxt_d;
            end else if (hen_q) begin
              data_q  <= hex2asc(hex_q[7:4]);
              state_q <= S_HEXHI;
            end else begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_HEXHI: begin
          if (xfer) begin
            data_q  <= hex2asc(hex_q[3:0]);
            state_q <= S_HEXLO;
          end
        end
        S_HEXLO: begin
          if (xfer) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr_o = addr_q;
  assign tx.data    = data_q;
  assign tx.valid   = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_char_printer.sv
// Directed bench for char_printer: table of print requests plus
// hand-written reset-mid-print sequence, against a small ROM model.
module tb_char_printer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hen;
  logic [3:0]  msg;
  logic [7:0]  hx;
  logic [3:0]  rom_addr;
  logic [63:0] rom_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  char_printer_if txif();

  char_printer #(.WIDTH(64), .DEPL2(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .msg_i      (msg),
    .hex_en_i   (hen),
    .hex_i      (hx),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .tx         (txif),
    .busy_o     (busy),
    .done_o     (done)
  );

  logic [63:0] rom [16];
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  msg;
    logic        hen;
    logic [7:0]  hx;
    int          rmode;
    int          start2;
    int          n;
    logic [95:0] b;
    int          dcyc;
  } vec_t;

  vec_t       v [7];
  logic [7:0] gotb [32];
  int         gotn;
  int         gotd;

  task automatic run(input logic [3:0] m, input logic he,
                     input logic [7:0] h, input int rmode,
                     input int start2);
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    pv = 1'b0;
    pr = 1'b0;
    pd = 8'h00;
    gotn = 0;
    gotd = -1;
    for (int c = 0; c < 80; c++) begin
      start = (c == 0) || (c == start2);
      msg = (c == 0) ? m : ~m;
      hen = (c == 0) ? he : ~he;
      hx = (c == 0) ? h : ~h;
      txif.ready = (rmode == 0) ? 1'b1 : (c % 3 == 0);
      @(negedge clk);
      if (pv && !pr) begin
        chk("hold_valid", 32'(txif.valid), 32'd1);
        chk("hold_data", 32'(txif.data), 32'(pd));
      end
      if (gotd < 0) begin
        chk("busy", 32'(busy), 32'(c >= 1));
      end else begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(txif.valid), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
      end
      if (gotd < 0 && txif.valid && txif.ready) begin
        if (gotn < 32) gotb[gotn] = txif.data;
        gotn++;
      end
      if (gotd < 0 && done) begin
        gotd = c;
        chk("done_valid", 32'(txif.valid), 32'd0);
      end
      pv = txif.valid;
      pr = txif.ready;
      pd = txif.data;
      @(posedge clk);
      #1;
      if (gotd >= 0 && c >= gotd + 3) break;
    end
    start = 1'b0;
    if (gotd < 0) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int ntx;
    for (int i = 0; i < 16; i++) rom[i] = 64'h0;
    rom[0] = 64'h68656C6C6F0A0000;
    rom[1] = 64'h457865637574650A;
    rom[2] = 64'h7374617475730A00;
    rom[3] = 64'h57726974650A2020;
    rom[4] = 64'h526561643A307800;

    v[0] = '{4'd0, 1'b0, 8'h00, 0, -1, 6,
             {48'h68656C6C6F0A, 48'h0}, 9};
    v[1] = '{4'd4, 1'b1, 8'hA5, 0, -1, 9,
             {72'h526561643A30784135, 24'h0}, 12};
    v[2] = '{4'd1, 1'b0, 8'h00, 0, -1, 8,
             {64'h457865637574650A, 32'h0}, 11};
    v[3] = '{4'd3, 1'b0, 8'h00, 1, -1, 8,
             {64'h57726974650A2020, 32'h0}, 25};
    v[4] = '{4'd9, 1'b0, 8'h00, 0, 1, 0, 96'h0, 3};
    v[5] = '{4'd9, 1'b1, 8'h3C, 0, -1, 2,
             {16'h3343, 80'h0}, 5};
    v[6] = '{4'd2, 1'b1, 8'h9F, 0, -1, 9,
             {56'h7374617475730A, 16'h3946, 24'h0}, 12};

    rst = 1'b1;
    start = 1'b0;
    hen = 1'b0;
    msg = 4'd0;
    hx = 8'h00;
    txif.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_data", 32'(txif.data), 32'd0);
    chk("rst_valid", 32'(txif.valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      run(v[t].msg, v[t].hen, v[t].hx, v[t].rmode, v[t].start2);
      chk($sformatf("v%0d_count", t), 32'(gotn), 32'(v[t].n));
      for (int i = 0; i < v[t].n && i < gotn; i++)
        chk($sformatf("v%0d_byte%0d", t, i), 32'(gotb[i]),
            32'(v[t].b[95-8*i -: 8]));
      chk($sformatf("v%0d_done_cyc", t), 32'(gotd), 32'(v[t].dcyc));
      chk($sformatf("v%0d_rom_addr", t), 32'(rom_addr), 32'(v[t].msg));
    end

    // Reset after the third byte of msg 2, then a clean print of msg 0.
    ntx = 0;
    txif.ready = 1'b1;
    hen = 1'b0;
    msg = 4'd2;
    for (int c = 0; c < 7; c++) begin
      start = (c == 0);
      rst = (c == 6);
      @(negedge clk);
      if (c < 6 && txif.valid && txif.ready) ntx++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_xfers", 32'(ntx), 32'd3);
    chk("mid_rst_valid", 32'(txif.valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_data", 32'(txif.data), 32'd0);
    @(posedge clk);
    #1;
    run(4'd0, 1'b0, 8'h00, 0, -1);
    chk("after_rst_count", 32'(gotn), 32'd6);
    for (int i = 0; i < 6 && i < gotn; i++)
      chk($sformatf("after_rst_byte%0d", i), 32'(gotb[i]),
          32'(v[0].b[95-8*i -: 8]));
    chk("after_rst_done_cyc", 32'(gotd), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
